// File: rtl/leaf_user_pkg.sv
// leaf_user_pkg: shared leaf packet constants, payload type and sizing helper
package leaf_user_pkg;
    localparam int PAYLOAD_BITS  = 32;
    localparam int PACKET_BITS   = 49;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    typedef logic [PAYLOAD_BITS-1:0] payload_t;
    function automatic int cnt_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/leaf_user_fifo.sv
// leaf_user_fifo: synchronous first-word-fall-through FIFO with occupancy count
module leaf_user_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   fill_q, fill_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = wdata;
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        fill_d = (push && !pop) ? fill_q + (AW+1)'(1) :
                 (!push && pop) ? fill_q - (AW+1)'(1) : fill_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    assign rdata = mem_q[rptr_q];
    assign fill  = fill_q;
endmodule

// File: rtl/leaf_user_rx_port.sv
// leaf_user_rx_port: leaf-to-user receive port, FWFT buffer + frame marking; LEAF_USER_RX_STATS_EN adds counters
module leaf_user_rx_port import leaf_user_pkg::*; #(
    parameter int PAYLOAD_BITS = leaf_user_pkg::PAYLOAD_BITS,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_WORDS  = 64
) (
    input  logic                          clk_user,
    input  logic                          reset,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user,
    input  logic                          vld_interface2user,
    output logic                          ack_user2interface,
    output logic [PAYLOAD_BITS-1:0]       m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fill
`ifdef LEAF_USER_RX_STATS_EN
    ,
    output logic [31:0]                   stat_words,
    output logic [31:0]                   stat_stall
`endif
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FW_W = cnt_bits(FRAME_WORDS);
    logic            push, pop;
    logic [FW_W-1:0] fcnt_q, fcnt_d;
    logic            frame_done_q, frame_done_d;
    // ack ignores a same-cycle pop so there is no m_ready-to-ack path
    assign ack_user2interface = !reset && (fill < (AW+1)'(FIFO_DEPTH));
    assign m_valid = fill != '0;
    assign m_last  = m_valid && (fcnt_q == FW_W'(FRAME_WORDS-1));
    assign push    = vld_interface2user && ack_user2interface;
    assign pop     = m_valid && m_ready;
    leaf_user_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_user),
        .rst   (reset),
        .push  (push),
        .wdata (dout_leaf_interface2user),
        .pop   (pop),
        .rdata (m_data),
        .fill  (fill)
    );
    always_comb begin
        fcnt_d       = pop ? (m_last ? '0 : fcnt_q + FW_W'(1)) : fcnt_q;
        frame_done_d = pop && m_last;
    end
    always_ff @(posedge clk_user) begin
        if (reset) begin
            fcnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            fcnt_q       <= fcnt_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign frame_done = frame_done_q;
`ifdef LEAF_USER_RX_STATS_EN
    logic [31:0] stat_words_q, stat_words_d, stat_stall_q, stat_stall_d;
    always_comb begin
        stat_words_d = stat_words_q + 32'(pop);
        stat_stall_d = stat_stall_q + 32'(vld_interface2user && !ack_user2interface && stat_stall_q != '1);
    end
    always_ff @(posedge clk_user) begin
        if (reset) begin
            stat_words_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_stall_q <= stat_stall_d;
        end
    end
    assign stat_words = stat_words_q;
    assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_leaf_user_rx_port.sv
// tb_leaf_user_rx_port: directed table, corner sequences and random traffic against a queue model
module tb_leaf_user_rx_port;
    localparam int DEPTH = 4;
    localparam int FW    = 3;
    logic        clk;
    logic        rst_i, vld_i, rdy_i;
    logic [31:0] din;
    logic        ack, m_valid, m_last, frame_done;
    logic [31:0] m_data;
    logic [2:0]  fill;
`ifdef LEAF_USER_RX_STATS_EN
    logic [31:0] stat_words, stat_stall;
`endif
    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];
    int          pos;
    bit          fd;
    logic [31:0] sw, ss;
    logic [31:0] last_words[$];
    int          fd_cnt;

    leaf_user_rx_port #(.PAYLOAD_BITS(32), .FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW)) dut (
        .clk_user                 (clk),
        .reset                    (rst_i),
        .dout_leaf_interface2user (din),
        .vld_interface2user       (vld_i),
        .ack_user2interface       (ack),
        .m_data                   (m_data),
        .m_valid                  (m_valid),
        .m_ready                  (rdy_i),
        .m_last                   (m_last),
        .frame_done               (frame_done),
        .fill                     (fill)
`ifdef LEAF_USER_RX_STATS_EN
        ,
        .stat_words               (stat_words),
        .stat_stall               (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, vld;
        logic [31:0] d;
        logic        rdy;
        logic        ack, vl;
        logic [31:0] dat;
        logic        last, fd;
        logic [2:0]  fill;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic rd);
        rst_i = r;
        vld_i = v;
        din   = d;
        rdy_i = rd;
        #1;
    endtask

    task automatic tick();
        bit can, push, pop, last, stall;
        can   = !rst_i && q.size() < DEPTH;
        push  = vld_i && can;
        stall = vld_i && !can;
        pop   = !rst_i && q.size() != 0 && rdy_i;
        last  = pop && pos == FW-1;
        if (m_valid && rdy_i && m_last) last_words.push_back(m_data);
        if (frame_done) fd_cnt++;
        @(posedge clk);
        if (rst_i) begin
            q.delete();
            pos = 0; fd = 0; sw = 0; ss = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                pos = (pos + 1) % FW;
                sw++;
            end
            if (push) q.push_back(din);
            if (stall && ss != 32'hFFFF_FFFF) ss++;
            fd = last;
        end
        #1;
    endtask

    task automatic mchk();
        chk("ack", 32'(ack), 32'(!rst_i && q.size() < DEPTH));
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        chk("fill", 32'(fill), q.size());
        chk("m_last", 32'(m_last), 32'(q.size() != 0 && pos == FW-1));
        chk("frame_done", 32'(frame_done), 32'(fd));
        if (q.size() != 0) chk("m_data", m_data, q[0]);
`ifdef LEAF_USER_RX_STATS_EN
        chk("stat_words", stat_words, sw);
        chk("stat_stall", stat_stall, ss);
`endif
    endtask

    task automatic cyc(input logic r, input logic v, input logic [31:0] d, input logic rd);
        drive(r, v, d, rd);
        mchk();
        tick();
    endtask

    initial begin
        tbl[0]  = '{1, 1, 32'h0,        0, 0, 0, 32'h0,        0, 0, 3'd0};
        tbl[1]  = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 3'd0};
        tbl[2]  = '{0, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0,        0, 0, 3'd0};
        tbl[3]  = '{0, 0, 32'h0,        0, 1, 1, 32'hDEADBEEF, 0, 0, 3'd1};
        tbl[4]  = '{0, 0, 32'h0,        1, 1, 1, 32'hDEADBEEF, 0, 0, 3'd1};
        tbl[5]  = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 3'd0};
        tbl[6]  = '{0, 1, 32'd1,        0, 1, 0, 32'h0,        0, 0, 3'd0};
        tbl[7]  = '{0, 1, 32'd2,        0, 1, 1, 32'd1,        0, 0, 3'd1};
        tbl[8]  = '{0, 1, 32'd3,        0, 1, 1, 32'd1,        0, 0, 3'd2};
        tbl[9]  = '{0, 1, 32'd4,        0, 1, 1, 32'd1,        0, 0, 3'd3};
        tbl[10] = '{0, 1, 32'd5,        0, 0, 1, 32'd1,        0, 0, 3'd4};
        tbl[11] = '{0, 1, 32'd5,        1, 0, 1, 32'd1,        0, 0, 3'd4};
        tbl[12] = '{0, 1, 32'd5,        0, 1, 1, 32'd2,        1, 0, 3'd3};
        tbl[13] = '{0, 0, 32'h0,        1, 0, 1, 32'd2,        1, 0, 3'd4};
        tbl[14] = '{0, 0, 32'h0,        1, 1, 1, 32'd3,        0, 1, 3'd3};
        tbl[15] = '{0, 0, 32'h0,        1, 1, 1, 32'd4,        0, 0, 3'd2};
        tbl[16] = '{0, 0, 32'h0,        1, 1, 1, 32'd5,        1, 0, 3'd1};
        tbl[17] = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 3'd0};
        pos = 0; fd = 0; sw = 0; ss = 0; fd_cnt = 0;
        drive(1, 0, 0, 0);
        tick();
        tick();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].d, tbl[i].rdy);
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].vl));
            chk($sformatf("tbl%0d_fill", i), 32'(fill), 32'(tbl[i].fill));
            chk($sformatf("tbl%0d_last", i), 32'(m_last), 32'(tbl[i].last));
            chk($sformatf("tbl%0d_fd", i), 32'(frame_done), 32'(tbl[i].fd));
            if (tbl[i].vl) chk($sformatf("tbl%0d_data", i), m_data, tbl[i].dat);
            tick();
        end
        cyc(1, 0, 0, 0);
        last_words.delete();
        fd_cnt = 0;
        for (int i = 1; i <= 7; i++) cyc(0, 1, 32'(i), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("frame_last_count", last_words.size(), 2);
        if (last_words.size() == 2) begin
            chk("frame_last_w0", last_words[0], 3);
            chk("frame_last_w1", last_words[1], 6);
        end
        chk("frame_done_count", fd_cnt, 2);
        last_words.delete();
        cyc(0, 1, 8, 1);
        cyc(0, 1, 9, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("fcnt_after7_lasts", last_words.size(), 1);
        if (last_words.size() == 1) chk("fcnt_after7_word", last_words[0], 9);
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 32'(16 + i), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("midframe_fill", 32'(fill), 2);
        chk("midframe_last", 32'(m_last), 1);
        tick();
        cyc(1, 1, 32'h55, 1);
        drive(0, 1, 32'hA5A5_0001, 0);
        chk("rst_flush_fill", 32'(fill), 0);
        chk("rst_flush_valid", 32'(m_valid), 0);
        tick();
        drive(0, 0, 0, 0);
        chk("new_frame_valid", 32'(m_valid), 1);
        chk("new_frame_data", m_data, 32'hA5A5_0001);
        chk("new_frame_last", 32'(m_last), 0);
        tick();
`ifdef LEAF_USER_RX_STATS_EN
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 32'(100 + i), 0);
        drive(0, 0, 0, 0);
        chk("stat_stall_10", stat_stall, 6);
        tick();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("stat_words_4", stat_words, 4);
        tick();
`endif
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
